// File: rtl/rx_cmd_pkg.sv
// Shared opcodes and FSM encoding for the byte-stream command controller.
package rx_cmd_pkg;

  localparam logic [7:0] OP_WR = 8'hAA;
  localparam logic [7:0] OP_RD = 8'hBB;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_WAIT = 3'd5
  } state_t;

  // States that wait on the host for the next byte and are therefore timed.
  function automatic logic timed_state(input state_t s);
    return (s == WR_ADDR) || (s == WR_DATA) || (s == RD_ADDR);
  endfunction

endpackage

// File: rtl/rx_cmd_ctrl_if.sv
// RX byte stream, register-file port and TX byte port of the command controller.
interface rx_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] RX_P_DATA;
  logic                  RX_D_VLD;
  logic [ADDR_WIDTH-1:0] RF_ADDR;
  logic                  RF_WR_EN;
  logic                  RF_RD_EN;
  logic [DATA_WIDTH-1:0] RF_WR_DATA;
  logic [DATA_WIDTH-1:0] RF_RD_DATA;
  logic                  RF_RD_VLD;
  logic [DATA_WIDTH-1:0] TX_P_DATA;
  logic                  TX_D_VLD;
  logic                  TX_BUSY;
  logic                  CMD_ERR;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RF_RD_DATA, RF_RD_VLD, TX_BUSY,
    output RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, TX_P_DATA, TX_D_VLD, CMD_ERR
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RF_RD_DATA, RF_RD_VLD, TX_BUSY,
    input  RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, TX_P_DATA, TX_D_VLD, CMD_ERR
  );
endinterface

// File: rtl/cmd_timeout_cnt.sv
// Inter-byte idle counter; tc flags the last allowed idle cycle while enabled.
module cmd_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 50000
)(
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  // Saturates at the terminal value so a stalled enable never wraps.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                     cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (en && cnt != TC_VAL) cnt <= cnt + 1'b1;
  end

  assign tc = en && (cnt == TC_VAL);
endmodule

// File: rtl/rx_cmd_ctrl.sv
// Decodes 0xAA/0xBB byte commands from RX into register-file writes and reads,
// returning read data on TX; malformed, stray or stalled commands pulse CMD_ERR.
module rx_cmd_ctrl
  import rx_cmd_pkg::*;
#(
  parameter int          DATA_WIDTH  = 8,
  parameter int          ADDR_WIDTH  = 4,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
)(
  input logic           CLK,
  input logic           RST,
  rx_cmd_ctrl_if.master bus
);
  localparam logic [DATA_WIDTH-1:0] OPW = DATA_WIDTH'(OP_WR);
  localparam logic [DATA_WIDTH-1:0] OPR = DATA_WIDTH'(OP_RD);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d, txd_q, txd_d;
  logic                  wr_q, wr_d, rd_q, rd_d, txv_q, txv_d, err_q, err_d;
  logic                  rx_vld, addr_ok, tmo_tc;

  assign rx_vld  = bus.RX_D_VLD;
  assign addr_ok = (bus.RX_P_DATA >> ADDR_WIDTH) == '0;

  cmd_timeout_cnt #(.TIMEOUT_CYC(32'(TIMEOUT_CYC))) u_tmo (
    .CLK (CLK),
    .RST (RST),
    .clr (rx_vld || !timed_state(state_q)),
    .en  (timed_state(state_q)),
    .tc  (tmo_tc)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    txd_d   = txd_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    txv_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (rx_vld) begin
        if (bus.RX_P_DATA == OPW)      state_d = WR_ADDR;
        else if (bus.RX_P_DATA == OPR) state_d = RD_ADDR;
        else                           err_d   = 1'b1;
      end
      WR_ADDR, RD_ADDR: begin
        // A byte arriving on the terminal count wins over the timeout.
        if (rx_vld) begin
          if (addr_ok) begin
            addr_d = bus.RX_P_DATA[ADDR_WIDTH-1:0];
            if (state_q == WR_ADDR) state_d = WR_DATA;
            else begin
              state_d = RD_WAIT;
              rd_d    = 1'b1;
            end
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (tmo_tc) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WR_DATA: begin
        if (rx_vld) begin
          wdat_d  = bus.RX_P_DATA;
          wr_d    = 1'b1;
          state_d = IDLE;
        end else if (tmo_tc) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      // Stray bytes while a read is in flight are dropped but flagged.
      RD_WAIT: begin
        err_d = rx_vld;
        if (bus.RF_RD_VLD) begin
          txd_d   = bus.RF_RD_DATA;
          state_d = TX_WAIT;
        end
      end
      TX_WAIT: begin
        err_d = rx_vld;
        if (!bus.TX_BUSY) begin
          txv_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdat_q  <= '0;
      txd_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      txv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      txd_q   <= txd_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      txv_q   <= txv_d;
      err_q   <= err_d;
    end
  end

  assign bus.RF_ADDR    = addr_q;
  assign bus.RF_WR_EN   = wr_q;
  assign bus.RF_RD_EN   = rd_q;
  assign bus.RF_WR_DATA = wdat_q;
  assign bus.TX_P_DATA  = txd_q;
  assign bus.TX_D_VLD   = txv_q;
  assign bus.CMD_ERR    = err_q;
endmodule

// File: doc/rx_cmd_ctrl.md
RX_CMD_CTRL -- requirements
Module: rx_cmd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width of RX/TX/register data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, register-file address width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 16'd50000, maximum idle clock cycles allowed between bytes of one command.
REQ-004 SHALL have ports: CLK in 1, clock; RST in 1, reset, asynchronous, active-low.
REQ-005 SHALL have ports: RX_P_DATA in DATA_WIDTH, received byte; RX_D_VLD in 1, one-cycle pulse qualifying RX_P_DATA.
REQ-006 SHALL have ports: RF_ADDR out ADDR_WIDTH, register address; RF_WR_EN out 1, write strobe; RF_RD_EN out 1, read strobe; RF_WR_DATA out DATA_WIDTH, write data.
REQ-007 SHALL have ports: RF_RD_DATA in DATA_WIDTH, read data; RF_RD_VLD in 1, one-cycle pulse qualifying RF_RD_DATA.
REQ-008 SHALL have ports: TX_P_DATA out DATA_WIDTH, byte to transmit; TX_D_VLD out 1, one-cycle transmit request; TX_BUSY in 1, transmitter busy.
REQ-009 SHALL have port CMD_ERR out 1, one-cycle pulse flagging an aborted or illegal command.

Function
REQ-010 All outputs SHALL be registered; RF_WR_EN, RF_RD_EN, TX_D_VLD and CMD_ERR SHALL be single-cycle pulses.
REQ-011 FSM states SHALL be IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_WAIT.
REQ-012 IDLE: on RX_D_VLD with byte 0xAA SHALL go to WR_ADDR; with 0xBB SHALL go to RD_ADDR; with any other byte SHALL pulse CMD_ERR the next cycle and stay in IDLE.
REQ-013 WR_ADDR/RD_ADDR: on RX_D_VLD with upper DATA_WIDTH-ADDR_WIDTH bits all zero, SHALL latch the low ADDR_WIDTH bits into RF_ADDR and go to WR_DATA or RD_WAIT respectively.
REQ-014 An address byte with any nonzero upper bit SHALL pulse CMD_ERR and return to IDLE with no register access.
REQ-015 WR_DATA: on RX_D_VLD at cycle n, SHALL drive RF_WR_DATA=byte and RF_WR_EN=1 at cycle n+1, then return to IDLE.
REQ-016 Entry to RD_WAIT SHALL pulse RF_RD_EN for exactly one cycle, with RF_ADDR stable.
REQ-017 RD_WAIT: on RF_RD_VLD SHALL latch RF_RD_DATA into TX_P_DATA and go to TX_WAIT.
REQ-018 TX_WAIT: the first cycle with TX_BUSY=0 SHALL pulse TX_D_VLD the following cycle and then return to IDLE; TX_P_DATA SHALL hold until the next read completes.
REQ-019 A timeout counter SHALL clear on entry to WR_ADDR, WR_DATA or RD_ADDR and on every RX_D_VLD, and SHALL increment each cycle spent in those states.
REQ-020 When the counter reaches TIMEOUT_CYC-1 with no RX_D_VLD, the block SHALL pulse CMD_ERR and return to IDLE.
REQ-021 RX_D_VLD during RD_WAIT or TX_WAIT SHALL drop the byte, pulse CMD_ERR and leave the state unchanged.
REQ-022 RD_WAIT and TX_WAIT SHALL have no timeout.
REQ-023 RX_D_VLD coinciding with a timeout terminal count SHALL be processed as a byte; the timeout SHALL be ignored.
REQ-024 Unreachable state encodings SHALL return to IDLE with all strobes low.

Reset
REQ-025 RST low SHALL asynchronously force IDLE; RF_ADDR, RF_WR_DATA and TX_P_DATA SHALL reset to 0, all strobes and CMD_ERR to 0, and the timeout counter to 0.
REQ-026 Reset asserted mid-command SHALL abort the command with no partial RF write and no TX request after release.

Structure
REQ-027 Opcode constants (0xAA write, 0xBB read) and the state encoding SHALL live in the shared package rx_cmd_pkg.
REQ-028 The timeout counter SHALL be the sub-module cmd_timeout_cnt (clear, enable, terminal-count output), sized by TIMEOUT_CYC.

Verification
REQ-029 Bench SHALL cover write: RX bytes 0xAA, 0x05, 0x3C -> one RF_WR_EN pulse with RF_ADDR=5 and RF_WR_DATA=0x3C, one cycle after the third RX_D_VLD.
REQ-030 Bench SHALL cover read: 0xBB, 0x02; RF returns 0x7E two cycles after RF_RD_EN, TX_BUSY=1 for 10 cycles -> single TX_D_VLD with TX_P_DATA=0x7E after TX_BUSY falls.
REQ-031 Bench SHALL cover illegal opcode and address: byte 0x12 in IDLE -> CMD_ERR pulse, no RF strobe; 0xAA then 0x15 -> CMD_ERR, return to IDLE.
REQ-032 Bench SHALL cover timeout: TIMEOUT_CYC=20, send 0xAA then nothing -> CMD_ERR exactly 20 cycles after entering WR_ADDR; the next 0xBB SHALL be accepted.
REQ-033 Bench SHALL cover a byte during a read: RX_D_VLD while in RD_WAIT -> CMD_ERR pulse, and the read still completes with a TX_D_VLD pulse.
REQ-034 Bench SHALL cover reset: RST asserted after 0xAA, 0x05 -> after release no RF_WR_EN, all outputs 0, and a fresh write executes normally.
